// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serialising memory controller: access sizes,
// FSM state encoding, requester identity and the size-to-byte-count helper.
package mem_ctrl_pkg;

    localparam logic [1:0] CU_W = 2'd0;
    localparam logic [1:0] CU_H = 2'd2;
    localparam logic [1:0] CU_B = 2'd3;

    localparam logic OWN_MM = 1'b0;
    localparam logic OWN_IF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Size code 1 is not a defined size and falls back to a word.
    function automatic logic [2:0] cu_bytes(input logic [1:0] cu);
        logic [2:0] n;
        case (cu)
            CU_H:    n = 3'd2;
            CU_B:    n = 3'd1;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MM requests onto one byte-wide synchronous RAM port and
// assembles little-endian results. Optional IF abort: MEM_CTRL_IF_ABORT_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_e,
    input  logic [ADDR_W-1:0] if_a,
    input  logic              if_flush,
    output logic [31:0]       if_n_o,
    output logic              if_ok,
    input  logic              mm_e,
    input  logic [ADDR_W-1:0] mm_a,
    input  logic [31:0]       mm_n_i,
    input  logic              mm_wr,
    input  logic [1:0]        mm_cu,
    output logic [31:0]       mm_n_o,
    output logic              mm_ok,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic              ram_wr,
    output logic              busy
);

    state_t            state_r, state_s;
    logic              own_r, own_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [2:0]        n_r, n_s;
    logic              wr_r, wr_s;
    logic [31:0]       data_r, data_s;
    logic [2:0]        k_r, k_s;
    logic [2:0]        r_r, r_s;
    logic [31:0]       asm_r, asm_s;
    logic [31:0]       fin_s;

    logic [ADDR_W-1:0] ram_a_r, ram_a_s;
    logic [7:0]        ram_din_r, ram_din_s;
    logic              ram_wr_r, ram_wr_s;
    logic              if_ok_r, if_ok_s;
    logic              mm_ok_r, mm_ok_s;
    logic [31:0]       if_n_o_r, if_n_o_s;
    logic [31:0]       mm_n_o_r, mm_n_o_s;
    logic              busy_r, busy_s;

    logic              flush_s;
    logic              acc_s;
    logic [ADDR_W-1:0] req_a_s;
    logic [2:0]        req_n_s;
    logic              req_wr_s;

`ifdef MEM_CTRL_IF_ABORT_EN
    assign flush_s = if_flush;
`else
    logic unused_flush_s;
    assign flush_s        = 1'b0;
    assign unused_flush_s = if_flush;
`endif

    // MM always wins; IF is only considered when MM is idle and no abort is pending.
    assign acc_s    = mm_e | (if_e & ~flush_s);
    assign req_a_s  = mm_e ? mm_a : if_a;
    assign req_n_s  = mm_e ? cu_bytes(mm_cu) : 3'd4;
    assign req_wr_s = mm_e & mm_wr;

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s   = state_r;
        own_s     = own_r;
        addr_s    = addr_r;
        n_s       = n_r;
        wr_s      = wr_r;
        data_s    = data_r;
        k_s       = k_r;
        r_s       = r_r;
        asm_s     = asm_r;
        fin_s     = asm_r;
        ram_a_s   = {ADDR_W{1'b0}};
        ram_din_s = 8'h00;
        ram_wr_s  = 1'b0;
        if_ok_s   = 1'b0;
        mm_ok_s   = 1'b0;
        if_n_o_s  = if_n_o_r;
        mm_n_o_s  = mm_n_o_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    own_s   = mm_e ? OWN_MM : OWN_IF;
                    addr_s  = req_a_s;
                    n_s     = req_n_s;
                    wr_s    = req_wr_s;
                    data_s  = mm_n_i;
                    k_s     = 3'd1;
                    r_s     = 3'd0;
                    asm_s   = 32'h0000_0000;
                    ram_a_s = req_a_s;
                    if (req_wr_s) begin
                        ram_wr_s  = 1'b1;
                        ram_din_s = mm_n_i[7:0];
                        state_s   = (req_n_s == 3'd1) ? ST_DONE : ST_WR;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (flush_s && (own_r == OWN_IF)) begin
                    state_s = ST_IDLE;
                end else begin
                    // Data lags its address by one cycle, so nothing arrives in the first RD cycle.
                    if ((r_r + 3'd1) < k_r) begin
                        asm_s[{r_r[1:0], 3'b000} +: 8] = ram_dout;
                        r_s = r_r + 3'd1;
                    end else begin
                        r_s = r_r;
                    end
                    if (k_r < n_r) begin
                        ram_a_s = addr_r + ADDR_W'(k_r);
                        k_s     = k_r + 3'd1;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
            end
            ST_WR: begin
                ram_a_s   = addr_r + ADDR_W'(k_r);
                ram_din_s = data_r[{k_r[1:0], 3'b000} +: 8];
                ram_wr_s  = 1'b1;
                k_s       = k_r + 3'd1;
                if (k_r == (n_r - 3'd1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_DONE: begin
                // The last read byte is still on ram_dout and is merged straight into the result.
                if (!wr_r) begin
                    fin_s[{r_r[1:0], 3'b000} +: 8] = ram_dout;
                end else begin
                    fin_s = asm_r;
                end
                if (own_r == OWN_IF) begin
                    if_ok_s  = 1'b1;
                    if_n_o_s = fin_s;
                end else begin
                    mm_ok_s  = 1'b1;
                    mm_n_o_s = fin_s;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, transaction context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            own_r     <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            n_r       <= 3'd0;
            wr_r      <= 1'b0;
            data_r    <= 32'h0000_0000;
            k_r       <= 3'd0;
            r_r       <= 3'd0;
            asm_r     <= 32'h0000_0000;
            ram_a_r   <= {ADDR_W{1'b0}};
            ram_din_r <= 8'h00;
            ram_wr_r  <= 1'b0;
            if_ok_r   <= 1'b0;
            mm_ok_r   <= 1'b0;
            if_n_o_r  <= 32'h0000_0000;
            mm_n_o_r  <= 32'h0000_0000;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            own_r     <= own_s;
            addr_r    <= addr_s;
            n_r       <= n_s;
            wr_r      <= wr_s;
            data_r    <= data_s;
            k_r       <= k_s;
            r_r       <= r_s;
            asm_r     <= asm_s;
            ram_a_r   <= ram_a_s;
            ram_din_r <= ram_din_s;
            ram_wr_r  <= ram_wr_s;
            if_ok_r   <= if_ok_s;
            mm_ok_r   <= mm_ok_s;
            if_n_o_r  <= if_n_o_s;
            mm_n_o_r  <= mm_n_o_s;
            busy_r    <= busy_s;
        end
    end

    assign ram_a   = ram_a_r;
    assign ram_din = ram_din_r;
    assign ram_wr  = ram_wr_r;
    assign if_ok   = if_ok_r;
    assign mm_ok   = mm_ok_r;
    assign if_n_o  = if_n_o_r;
    assign mm_n_o  = mm_n_o_r;
    assign busy    = busy_r;

endmodule
